// File: rtl/jtvigil_pcm_if.sv
// jtvigil_pcm_if: PCM ROM request port between the sample player and the SDRAM block
interface jtvigil_pcm_if #(parameter int AW = 16);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;
  modport master(output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave(input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jtvigil_pcm.sv
// jtvigil_pcm: autonomous 8-bit PCM sample player; define JTVIGIL_PCM_LPF_EN for two-tap output averaging
module jtvigil_pcm #(
  parameter int AW  = 16,
  parameter int DIV = 448
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic [7:0]        din,
  input  logic              lo_we,
  input  logic              hi_we,
  input  logic              play_we,
  input  logic              stop_we,
  jtvigil_pcm_if.master     pcm,
  output logic signed [7:0] snd,
  output logic              sample,
  output logic              busy,
  output logic              ovr
);
  localparam int CW = $clog2(DIV);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, REQ = 2'd2, CHK = 2'd3;
  logic [1:0]        st;
  logic [15:0]       start, start_nx;
  logic [CW-1:0]     cnt;
  logic              tick, arm, cap;
  logic [7:0]        dat;
  logic signed [7:0] raw, out;
  // write-through so a byte written alongside play_we is used immediately
  assign start_nx = {hi_we ? din : start[15:8], lo_we ? din : start[7:0]};
  assign tick     = cen && cnt == CW'(DIV - 1);
  assign raw      = pcm.rom_data ^ 8'h80;
  assign cap      = st == REQ && arm && pcm.rom_ok;
`ifdef JTVIGIL_PCM_LPF_EN
  logic signed [7:0] prev;
  logic signed [8:0] sum;
  assign sum = {prev[7], prev} + {raw[7], raw};
  assign out = 8'(sum >>> 1);
  always_ff @(posedge clk)
    if (rst || stop_we || play_we) prev <= '0;
    else if (cap && pcm.rom_data != 8'd0) prev <= raw;
`else
  assign out = raw;
`endif
  always_ff @(posedge clk)
    start <= rst ? '0 : start_nx;
  always_ff @(posedge clk)
    if (rst || play_we) cnt <= '0;
    else if (cen) cnt <= tick ? '0 : cnt + 1'b1;
  always_ff @(posedge clk) begin
    sample <= 1'b0;
    if (rst) begin
      st           <= IDLE;
      pcm.rom_addr <= '0;
      pcm.rom_cs   <= 1'b0;
      snd          <= '0;
      busy         <= 1'b0;
      ovr          <= 1'b0;
      arm          <= 1'b0;
      dat          <= '0;
    end else if (stop_we) begin
      st         <= IDLE;
      pcm.rom_cs <= 1'b0;
      snd        <= '0;
      busy       <= 1'b0;
    end else if (play_we) begin
      st           <= WAIT;
      pcm.rom_addr <= AW'(start_nx);
      pcm.rom_cs   <= 1'b0;
      busy         <= 1'b1;
      ovr          <= 1'b0;
    end else begin
      if (tick && (st == REQ || st == CHK)) ovr <= 1'b1;
      case (st)
        WAIT: if (tick) begin
          st         <= REQ;
          pcm.rom_cs <= 1'b1;
          arm        <= 1'b0;
        end
        REQ: begin
          // first REQ cycle is skipped: rom_ok may still refer to an older request
          arm <= 1'b1;
          if (cap) begin
            st         <= CHK;
            pcm.rom_cs <= 1'b0;
            dat        <= pcm.rom_data;
            snd        <= pcm.rom_data == 8'd0 ? 8'sd0 : out;
            sample     <= pcm.rom_data != 8'd0;
          end
        end
        CHK: if (dat == 8'd0) begin
          st   <= IDLE;
          busy <= 1'b0;
        end else begin
          st           <= WAIT;
          pcm.rom_addr <= pcm.rom_addr + 1'b1;
        end
        default: snd <= '0;
      endcase
    end
  end
endmodule

// File: doc/jtvigil_pcm.md
Name: jtvigil_pcm

Overview:
- Autonomous 8-bit PCM sample player on the sound side of the Vigilante core.
- Sits between the sound CPU bus and the PCM ROM port (`pcm_addr`/`pcm_cs`/`pcm_data`/`pcm_ok`) that the SDRAM block serves.
- The sound CPU latches a 16-bit start address and issues a play command. The block then fetches one byte per sample period and emits a signed sample to the sound mixer, stopping at a 0x00 terminator byte.

Parameters:
- AW, 16, PCM ROM address width.
- DIV, 448, number of `cen` pulses per output sample (3.579 MHz / 448 ≈ 7.99 kHz).

Ports:
- clk  in  1  system clock (clk24 domain).
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable, 3.579 MHz CPU cen.
- din  in  8  sound CPU data bus.
- lo_we  in  1  one-cycle strobe; latches din into start address [7:0].
- hi_we  in  1  one-cycle strobe; latches din into start address [15:8].
- play_we  in  1  one-cycle strobe; starts playback from the latched start address.
- stop_we  in  1  one-cycle strobe; aborts playback.
- rom_addr  out  AW  PCM ROM byte address.
- rom_cs  out  1  ROM request.
- rom_data  in  8  ROM byte.
- rom_ok  in  1  ROM data valid.
- snd  out  8 (signed)  sample output.
- sample  out  1  one-cycle pulse when snd updates.
- busy  out  1  high while playing.
- ovr  out  1  sticky overrun flag, cleared on play_we.

Behaviour:
- Clocking and reset:
  - Single clock, synchronous active-high reset.
  - Reset values: rom_addr=0, rom_cs=0, snd=0, sample=0, busy=0, ovr=0, start latch=0, divider=0, FSM=IDLE.
  - Reset mid-fetch drops rom_cs the next cycle; no partial sample is emitted.
- Start address latch: lo_we/hi_we update their byte regardless of FSM state. They do not affect rom_addr until the next play_we.
- Divider:
  - Counts cen pulses from 0 to DIV-1. On reaching DIV-1 with cen high, it wraps to 0 and raises the internal tick for one clk.
  - The divider runs freely and is reset to 0 on play_we.
- FSM states: IDLE, WAIT, REQ, CHK.
- IDLE:
  - busy=0, rom_cs=0, snd held at 0.
  - play_we → rom_addr=start latch, busy=1, ovr=0, go to WAIT.
- WAIT: on tick → assert rom_cs, go to REQ.
- REQ:
  - rom_cs held high. The first cycle after rom_cs rises or rom_addr changes is ignored (stale rom_ok).
  - From the second cycle on, rom_ok=1 → capture rom_data, drop rom_cs, go to CHK.
- CHK (one cycle):
  - Byte 0x00 → snd=0, busy=0, go to IDLE; no sample pulse.
  - Any other byte → snd = byte XOR 0x80 (offset-binary to two's complement), sample=1 for exactly this cycle, rom_addr+1, go to WAIT.
  - Address wraps 0xFFFF→0x0000 silently; playback continues.
- Overrun: a tick that arrives while in REQ or CHK sets ovr=1 and is otherwise dropped. The next sample waits for the following tick.
- stop_we:
  - Any state → IDLE next cycle, rom_cs=0, snd=0, busy=0.
  - stop_we and play_we in the same cycle: stop wins.
- play_we while busy: restart from the start latch. Any outstanding request is abandoned, rom_cs drops for one cycle, then the FSM enters WAIT.
- lo_we/hi_we in the same cycle as play_we: the new byte is used for the start address (write-through).
- Latency: tick → rom_cs high next clk. rom_ok → sample pulse 1 clk later.

Optional Feature:
- JTVIGIL_PCM_LPF_EN:
  - When defined, the emitted value is a two-tap average: snd = (prev + cur) >>> 1. The sum is formed as 9-bit signed with an arithmetic shift.
  - prev is the last emitted raw sample, reset to 0 on play_we and stop.
  - The 0x00 terminator still forces snd=0 immediately.
- Without the macro, snd equals the raw converted byte.

Test Plan:
- Basic playback: lo=0x34, hi=0x12, play; ROM bytes 0x80,0xFF,0x00 at 0x1234..0x1236, rom_ok 3 cycles after cs. Expect snd 0x00, then 0x7F, with exactly 2 sample pulses spaced DIV cen. After the terminator busy=0, snd=0, rom_addr=0x1236.
- Wrap: start 0xFFFF with ROM[0xFFFF]=0x90 and ROM[0x0000]=0x00. Expect one sample of 0x10, then a fetch at 0x0000 and stop.
- Overrun: hold rom_ok low for more than DIV cen. Expect ovr=1, no sample lost-ordering (bytes emitted in address order), busy stays 1. ovr clears on the next play.
- Stop/play collision: stop_we and play_we in the same cycle while playing. Expect IDLE, rom_cs=0, busy=0.
- Stale ok: rom_ok already high when rom_cs rises. The byte must not be captured on the first cycle; capture occurs on the second cycle.
- LPF (macro on): bytes 0xC0 then 0x40 (raw 0x40, then 0xC0). Expect snd 0x20, then 0x00.
